sum_bcd_converter: RTL and testbench
====================================

Name: sum_bcd_converter

Overview:
Downstream consumer of the 8-bit adder result in the calculator datapath. Takes the two's-complement sum when the adder signals completion and converts it into a sign flag plus BCD digits for the display stage. Uses a sequential shift-add-3 (double-dabble) engine, one bit per clock. Issues a one-cycle done pulse when the digits are valid.

Parameters:
WIDTH, 8, width of the signed input value in bits.
DIGITS, 3, number of BCD output digits. 10^DIGITS must be greater than or equal to 2^(WIDTH-1).

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous active-high reset.
start  input  1  one-cycle request; normally tied to the adder's done_sum.
value  input  WIDTH  two's-complement sum from the adder; sampled only when start is accepted.
busy  output  1  high while a conversion is in progress (CONVERT state).
done  output  1  one-cycle pulse; digit and sign outputs are valid from this cycle onward.
sign  output  1  1 = value was negative.
bcd  output  4*DIGITS  BCD digits; [3:0] = ones, [7:4] = tens, [11:8] = hundreds.

Behaviour:
- Reset is asynchronous and active-high. Reset forces: state IDLE, busy=0, done=0, sign=0, bcd=0, internal shift and BCD registers 0, bit counter 0.
- States:
  - IDLE: done=0, busy=0. If start=1 at a rising edge, the block:
    - captures sign_r = value[WIDTH-1];
    - loads magnitude = value[WIDTH-1] ? (~value + 1) : value, computed WIDTH bits wide and zero-extended;
    - clears working BCD;
    - sets counter = WIDTH;
    - moves to CONVERT.
  - CONVERT: busy=1. On each edge, every working BCD nibble >= 5 gets +3 added. Then {bcd_work, magnitude} shifts left by 1 and the counter decrements. When the counter reaches 0 after the final shift, the state moves to DONE.
  - DONE: on entry edge, sign and bcd are registered from sign_r and bcd_work, done=1 for this one cycle, and busy=0. The next edge returns to IDLE.
- Latency: the edge that samples start is edge 0. Conversion uses edges 1..WIDTH. Outputs update and done rises at edge WIDTH+1 (edge 9 for WIDTH=8).
- Most-negative input: 0x80 has magnitude 128. The unsigned WIDTH-bit negation of 0x80 yields 0x80, which is correct.
- Zero: 0x00 gives sign=0 and bcd=000.
- start outside IDLE: ignored in CONVERT and DONE. No queuing; the in-flight conversion is unaffected.
- Input stability: value may change after the start edge without affecting the result.
- Output hold: sign and bcd keep the last result until the next DONE. They are not cleared at the next start.
- Reset mid-conversion: immediate return to IDLE with all outputs 0. No done pulse is produced for the aborted conversion.
- start held high continuously: a new conversion begins on the first IDLE edge after each DONE, i.e. every WIDTH+2 cycles.

Optional Feature:
Macro: SUM_BCD_SEG7_EN
- Defined:
  - Adds output seg [7*DIGITS-1:0], active-high segments {g,f,e,d,c,b,a} per digit, ones in [6:0].
  - Adds output seg_minus (1 bit), equal to sign.
  - Both are registered on the same edge as bcd and reset to 0.
  - Encoding: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Non-BCD nibble codes give 0x00.
- Undefined: the seg and seg_minus ports do not exist. All other behaviour is identical.

Test Plan:
- value=0x7F, start pulse → done at edge 9 after start, sign=0, bcd=0x127, busy high for exactly 8 cycles.
- value=0x80 → sign=1, bcd=0x128. With SUM_BCD_SEG7_EN: seg[20:14]=0x06, seg[13:7]=0x5B, seg[6:0]=0x7F.
- value=0xF6 → sign=1, bcd=0x010. Then value=0x00 → sign=0, bcd=0x000, done pulse width exactly 1 cycle.
- value=0x2A accepted; start with value=0x55 at edge 3 → ignored. Result sign=0, bcd=0x042, single done pulse.
- value=0x63 converted (bcd=0x099), then value=0xC0 start and rst asserted at edge 4 asynchronously → outputs 0 immediately, no done. After release, value=0xC0 → sign=1, bcd=0x064.
- start held high with value=0x0C → done pulses every 10 cycles, bcd=0x012 each time.

Source files
------------

// File: rtl/sum_bcd_converter.sv
// sum_bcd_converter: turns the adder's two's-complement sum into a sign flag
// plus BCD digits using a serial shift-add-3 (double-dabble) engine that
// handles one magnitude bit per clock.
//
// Handshake: start is a one-cycle request that is only honoured in IDLE. The
// block then shows busy for WIDTH cycles, and done is a single-cycle pulse.
// sign/bcd become valid together with done and keep their value until the
// next done. start in any other state is dropped; nothing is queued.
//
// Optional build macro SUM_BCD_SEG7_EN adds seven-segment outputs (seg,
// seg_minus). These are registered on the same edge as bcd.
// state_dbg exposes the FSM state (0=IDLE, 1=CONVERT, 2=DONE).
module sum_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
`ifdef SUM_BCD_SEG7_EN
  output logic [7*DIGITS-1:0]   seg,
  output logic                  seg_minus,
`endif
  output logic [1:0]            state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state;
  logic             sign_r;
  logic [WIDTH-1:0] mag_r;
  logic [BW-1:0]    bcd_work;
  logic [BW-1:0]    bcd_adj;
  logic [CW-1:0]    cnt_r;

  assign state_dbg = state;

`ifdef SUM_BCD_SEG7_EN
  logic [7*DIGITS-1:0] seg_next;

  // Active-high {g,f,e,d,c,b,a}; codes above 9 blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Segment patterns for the finished working digits.
  always_comb begin
    seg_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_next[7*i +: 7] = seg7(bcd_work[4*i +: 4]);
    end
  end
`endif

  // Add-3 correction: any nibble >= 5 is bumped before the next shift.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
    end
  end

  // Control FSM, shift engine and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      bcd      <= '0;
      sign_r   <= 1'b0;
      mag_r    <= '0;
      bcd_work <= '0;
      cnt_r    <= '0;
`ifdef SUM_BCD_SEG7_EN
      seg       <= '0;
      seg_minus <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_r   <= value[WIDTH-1];
            // Unsigned negation also covers the most-negative code: the
            // result reads correctly as the magnitude 2^(WIDTH-1).
            mag_r    <= value[WIDTH-1] ? (~value + 1'b1) : value;
            bcd_work <= '0;
            cnt_r    <= CW'(WIDTH);
            busy     <= 1'b1;
            state    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd_work <= {bcd_adj[BW-2:0], mag_r[WIDTH-1]};
          mag_r    <= {mag_r[WIDTH-2:0], 1'b0};
          cnt_r    <= cnt_r - 1'b1;
          if (cnt_r == CW'(1)) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          sign  <= sign_r;
          bcd   <= bcd_work;
          done  <= 1'b1;
          state <= S_IDLE;
`ifdef SUM_BCD_SEG7_EN
          seg       <= seg_next;
          seg_minus <= sign_r;
`endif
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_bcd_converter.sv
// tb_sum_bcd_converter: randomized plus directed bench for sum_bcd_converter.
// Expected results are pushed into a queue when a start is accepted. A monitor
// pops an entry on each done and also checks busy, done width and output hold
// on every cycle.
module tb_sum_bcd_converter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;
  localparam int LAT    = WIDTH + 1;   // start edge -> done edge
  localparam int PERIOD = WIDTH + 2;   // back-to-back start spacing
  localparam int EW     = BW + 1;      // {sign, bcd}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [WIDTH-1:0]  value;
  logic              busy;
  logic              done;
  logic              sign;
  logic [BW-1:0]     bcd;
  logic [1:0]        state_dbg;
`ifdef SUM_BCD_SEG7_EN
  logic [7*DIGITS-1:0] seg;
  logic                seg_minus;
`endif

  sum_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .sign      (sign),
    .bcd       (bcd),
`ifdef SUM_BCD_SEG7_EN
    .seg       (seg),
    .seg_minus (seg_minus),
`endif
    .state_dbg (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_t[$];
  logic [EW-1:0] hold_exp = '0;
  int            acc_edge = -100;
  int            free_at  = 0;
  logic          prev_done = 1'b0;
  int            total = 0;
  int            bad   = 0;

  // Reference: sign plus decimal digits of |value| using plain arithmetic.
  function automatic logic [EW-1:0] ref_model(input logic [WIDTH-1:0] v);
    int mag;
    logic [BW-1:0] d;
    mag = v[WIDTH-1] ? (1 << WIDTH) - int'(v) : int'(v);
    d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {v[WIDTH-1], d};
  endfunction

`ifdef SUM_BCD_SEG7_EN
  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  function automatic logic [7*DIGITS-1:0] seg_ref(input logic [BW-1:0] d);
    logic [7*DIGITS-1:0] s;
    for (int i = 0; i < DIGITS; i++) s[7*i +: 7] = seg_tab[int'(d[4*i +: 4])];
    return s;
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  // Output changes happen just after posedge, so every check samples on negedge.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 32'(busy), 32'((acc_edge >= 0) && (cyc - acc_edge) < WIDTH));
      if (done) begin
        check("done_width", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          hold_exp = exp_q.pop_front();
          check("done_latency", 32'(cyc), 32'(exp_t.pop_front() + LAT));
        end
      end
      check("sign_bcd", 32'({sign, bcd}), 32'(hold_exp));
`ifdef SUM_BCD_SEG7_EN
      check("seg", 32'(seg), 32'(seg_ref(hold_exp[BW-1:0])));
      check("seg_minus", 32'(seg_minus), 32'(hold_exp[BW]));
`endif
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  // Presents one start; the model decides whether the DUT was free to take it.
  task automatic issue(input logic [WIDTH-1:0] v);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    if (cyc >= free_at) begin
      exp_q.push_back(ref_model(v));
      exp_t.push_back(cyc);
      acc_edge = cyc;
      free_at  = cyc + PERIOD;
    end
    start = 1'b0;
    value = WIDTH'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sign_bcd"}, 32'({sign, bcd}), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
`ifdef SUM_BCD_SEG7_EN
    check({tag, "_seg"}, 32'(seg), 32'd0);
    check({tag, "_seg_minus"}, 32'(seg_minus), 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed corner values.
    issue(8'h7F); drain();
    issue(8'h80); drain();
    issue(8'hF6); drain();
    issue(8'h00); drain();

    // A start during CONVERT must be ignored.
    issue(8'h2A);
    repeat (2) @(negedge clk);
    issue(8'h55);
    drain();

    // Reset in the middle of a conversion aborts it with no done.
    issue(8'h63); drain();
    issue(8'hC0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    exp_t.delete();
    hold_exp = '0;
    acc_edge = -100;
    free_at  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(8'hC0); drain();

    // start held high: a new conversion every PERIOD cycles.
    for (int i = 0; i < 35; i++) issue(8'h0C);
    drain();

    // Random values with random gaps, including starts that land while busy.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      issue(WIDTH'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
